// File: rtl/usb_fs_packet_rx_pkg.sv
// Shared constants for the USB full-speed receive path: PIDs, SYNC, CRC parameters,
// line states and the PID-to-CRC classification helper.
package usb_fs_packet_rx_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ERROR} rx_state_e;
    typedef enum logic [1:0] {CRC_NONE, CRC_5, CRC_16} crc_class_e;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;

    // Bit i is the i-th decoded SYNC bit on the wire (KJKJKJKK).
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    localparam logic [4:0]  CRC5_POLY     = 5'h05;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    function automatic crc_class_e pid_crc_class(input logic [3:0] pid);
        case (pid)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP:        return CRC_5;
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: return CRC_16;
            default:                                    return CRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC checker: register preset to all ones, one bit per bit_valid,
// residue_ok when the register holds the expected residue.
module usb_crc_serial #(
    parameter int unsigned        WIDTH   = 5,
    parameter logic [WIDTH-1:0]   POLY    = '0,
    parameter logic [WIDTH-1:0]   RESIDUE = '0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic residue_ok
);

    logic [WIDTH-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '1;
        end else if (bit_valid) begin
            crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ ((bit_in ^ crc_q[WIDTH-1]) ? POLY : '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) crc_q <= '1;
        else          crc_q <= crc_d;
    end

    assign residue_ok = (crc_q == RESIDUE);

endmodule

// File: rtl/usb_fs_packet_rx.sv
// USB full-speed receive engine: pin synchronizer, oversampled bit recovery,
// SYNC/NRZI/destuff/EOP state machine, byte assembly and PID/CRC checks.
module usb_fs_packet_rx
    import usb_fs_packet_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 4,
    parameter int unsigned MAX_BYTES  = 1027,
    parameter int unsigned COUNT_W    = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               dp,
    input  logic               dn,
    output logic               rx_active,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    output logic [3:0]         rx_pid,
    output logic [COUNT_W-1:0] rx_byte_count,
    output logic               rx_done,
    output logic               rx_crc_ok,
    output logic               rx_error
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);

    logic dp_meta_q, dp_sync_q, dn_meta_q, dn_sync_q;
    line_state_e line_st, line_prev_q, nrzi_prev_q, nrzi_prev_d;
    rx_state_e state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d, phase_eff;
    logic [2:0] bit_cnt_q, bit_cnt_d, ones_q, ones_d;
    logic [1:0] se0_cnt_q, se0_cnt_d;
    logic j_seen_q, j_seen_d;
    logic [7:0] shift_q, shift_d;
    logic rx_active_q, rx_active_d, rx_valid_q, rx_valid_d;
    logic rx_done_q, rx_done_d, rx_crc_ok_q, rx_crc_ok_d, rx_error_q, rx_error_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [3:0] rx_pid_q, rx_pid_d;
    logic [COUNT_W-1:0] rx_byte_count_q, rx_byte_count_d;
    logic trans, sample, dec_bit, abort;
    logic crc_clear, crc_valid, crc5_ok, crc16_ok, crc_ok_now;

    assign line_st = line_state_e'({dp_sync_q, dn_sync_q});

    usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .RESIDUE(CRC5_RESIDUE)) u_crc5 (
        .clock(clock), .reset_n(reset_n), .clear(crc_clear), .bit_valid(crc_valid),
        .bit_in(dec_bit), .residue_ok(crc5_ok)
    );

    usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .RESIDUE(CRC16_RESIDUE)) u_crc16 (
        .clock(clock), .reset_n(reset_n), .clear(crc_clear), .bit_valid(crc_valid),
        .bit_in(dec_bit), .residue_ok(crc16_ok)
    );

    always_comb begin
        case (pid_crc_class(rx_pid_q))
            CRC_5:   crc_ok_now = crc5_ok && (rx_byte_count_q == COUNT_W'(3));
            CRC_16:  crc_ok_now = crc16_ok && (rx_byte_count_q >= COUNT_W'(3));
            default: crc_ok_now = (rx_byte_count_q == COUNT_W'(1));
        endcase
    end

    always_comb begin
        // A line transition marks phase 0 of the new bit; sample mid-bit.
        trans     = (line_st != line_prev_q);
        phase_eff = trans ? '0 : phase_q;
        sample    = (phase_eff == PH_W'(OVERSAMPLE / 2));
        phase_d   = (phase_eff == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_eff + 1'b1;
        dec_bit   = (line_st == nrzi_prev_q);

        state_d = state_q;           nrzi_prev_d = nrzi_prev_q;
        bit_cnt_d = bit_cnt_q;       ones_d = ones_q;
        se0_cnt_d = se0_cnt_q;       j_seen_d = j_seen_q;
        shift_d = shift_q;           rx_active_d = rx_active_q;
        rx_data_d = rx_data_q;       rx_pid_d = rx_pid_q;
        rx_byte_count_d = rx_byte_count_q;
        rx_crc_ok_d = rx_crc_ok_q;
        rx_valid_d = 1'b0;           rx_done_d = 1'b0;
        rx_error_d = 1'b0;           abort = 1'b0;
        crc_clear = 1'b0;            crc_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trans && line_st == LS_K && line_prev_q == LS_J) begin
                    state_d     = ST_SYNC;
                    bit_cnt_d   = '0;
                    nrzi_prev_d = LS_J;
                end
            end
            ST_SYNC: begin
                if (sample) begin
                    if (line_st == LS_SE0 || line_st == LS_SE1 || dec_bit != SYNC_PATTERN[bit_cnt_q]) begin
                        state_d = ST_IDLE;
                    end else begin
                        nrzi_prev_d = line_st;
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d         = ST_DATA;
                            rx_active_d     = 1'b1;
                            ones_d          = 3'd1;
                            rx_byte_count_d = '0;
                            crc_clear       = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    if (line_st == LS_SE0) begin
                        state_d   = ST_EOP;
                        se0_cnt_d = 2'd1;
                    end else if (line_st == LS_SE1) begin
                        abort = 1'b1;
                    end else begin
                        nrzi_prev_d = line_st;
                        if (ones_q == 3'd6) begin
                            abort  = dec_bit;
                            ones_d = '0;
                        end else begin
                            ones_d    = dec_bit ? ones_q + 3'd1 : '0;
                            shift_d   = {dec_bit, shift_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            crc_valid = (rx_byte_count_q != '0);
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_d       = shift_d;
                                rx_valid_d      = 1'b1;
                                rx_byte_count_d = rx_byte_count_q + 1'b1;
                                if (rx_byte_count_q == '0) begin
                                    rx_pid_d = shift_d[3:0];
                                    abort    = (shift_d[7:4] != ~shift_d[3:0]);
                                end
                                if (rx_byte_count_q == COUNT_W'(MAX_BYTES)) abort = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_EOP: begin
                if (sample) begin
                    if (line_st == LS_SE0) begin
                        abort     = (se0_cnt_q == 2'd2);
                        se0_cnt_d = se0_cnt_q + 2'd1;
                    end else if (line_st == LS_J && bit_cnt_q == 3'd0) begin
                        state_d     = ST_IDLE;
                        rx_done_d   = 1'b1;
                        rx_active_d = 1'b0;
                        rx_crc_ok_d = crc_ok_now;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                if (sample) begin
                    j_seen_d = (line_st == LS_J);
                    if (line_st == LS_J && j_seen_q) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_ERROR;
            rx_error_d  = 1'b1;
            rx_valid_d  = 1'b0;
            rx_active_d = 1'b0;
            j_seen_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dp_meta_q <= 1'b0;  dp_sync_q <= 1'b0;
            dn_meta_q <= 1'b0;  dn_sync_q <= 1'b0;
            line_prev_q <= LS_SE0;  nrzi_prev_q <= LS_J;
            state_q <= ST_IDLE;     phase_q <= '0;
            bit_cnt_q <= '0;  ones_q <= '0;  se0_cnt_q <= '0;  j_seen_q <= 1'b0;
            shift_q <= '0;    rx_active_q <= 1'b0;  rx_data_q <= '0;
            rx_valid_q <= 1'b0;  rx_pid_q <= '0;  rx_byte_count_q <= '0;
            rx_done_q <= 1'b0;   rx_crc_ok_q <= 1'b0;  rx_error_q <= 1'b0;
        end else begin
            dp_meta_q <= dp;  dp_sync_q <= dp_meta_q;
            dn_meta_q <= dn;  dn_sync_q <= dn_meta_q;
            line_prev_q <= line_st;  nrzi_prev_q <= nrzi_prev_d;
            state_q <= state_d;      phase_q <= phase_d;
            bit_cnt_q <= bit_cnt_d;  ones_q <= ones_d;
            se0_cnt_q <= se0_cnt_d;  j_seen_q <= j_seen_d;
            shift_q <= shift_d;      rx_active_q <= rx_active_d;
            rx_data_q <= rx_data_d;  rx_valid_q <= rx_valid_d;
            rx_pid_q <= rx_pid_d;    rx_byte_count_q <= rx_byte_count_d;
            rx_done_q <= rx_done_d;  rx_crc_ok_q <= rx_crc_ok_d;
            rx_error_q <= rx_error_d;
        end
    end

    assign rx_active     = rx_active_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_pid        = rx_pid_q;
    assign rx_byte_count = rx_byte_count_q;
    assign rx_done       = rx_done_q;
    assign rx_crc_ok     = rx_crc_ok_q;
    assign rx_error      = rx_error_q;

endmodule

// File: tb/tb_usb_fs_packet_rx.sv
// Directed bench for usb_fs_packet_rx: builds NRZI/stuffed line waveforms from byte
// lists (CRC16 via the reflected software form) and checks bytes, counts and status.
module tb_usb_fs_packet_rx;

    logic clock, reset_n;
    logic dp_drv, dn_drv, sel;
    logic dp4, dn4, dp8, dn8;

    logic a4, v4, d4, c4, e4, a8, v8, d8, c8, e8;
    logic [7:0] dat4, dat8;
    logic [3:0] pid4, pid8;
    logic [10:0] cnt4, cnt8;

    logic m_active, m_valid, m_done, m_crc_ok, m_error;
    logic [7:0] m_data;
    logic [3:0] m_pid;
    logic [10:0] m_count;

    assign dp4 = sel ? 1'b1 : dp_drv;
    assign dn4 = sel ? 1'b0 : dn_drv;
    assign dp8 = sel ? dp_drv : 1'b1;
    assign dn8 = sel ? dn_drv : 1'b0;

    usb_fs_packet_rx #(.OVERSAMPLE(4), .MAX_BYTES(1027), .COUNT_W(11)) u_dut (
        .clock(clock), .reset_n(reset_n), .dp(dp4), .dn(dn4),
        .rx_active(a4), .rx_data(dat4), .rx_valid(v4), .rx_pid(pid4),
        .rx_byte_count(cnt4), .rx_done(d4), .rx_crc_ok(c4), .rx_error(e4)
    );

    usb_fs_packet_rx #(.OVERSAMPLE(8), .MAX_BYTES(1027), .COUNT_W(11)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .dp(dp8), .dn(dn8),
        .rx_active(a8), .rx_data(dat8), .rx_valid(v8), .rx_pid(pid8),
        .rx_byte_count(cnt8), .rx_done(d8), .rx_crc_ok(c8), .rx_error(e8)
    );

    assign m_active = sel ? a8 : a4;
    assign m_valid  = sel ? v8 : v4;
    assign m_done   = sel ? d8 : d4;
    assign m_crc_ok = sel ? c8 : c4;
    assign m_error  = sel ? e8 : e4;
    assign m_data   = sel ? dat8 : dat4;
    assign m_pid    = sel ? pid8 : pid4;
    assign m_count  = sel ? cnt8 : cnt4;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [7:0] got_q[$];
    int unsigned done_n = 0, err_n = 0;
    logic last_crc_ok = 1'b0;
    logic [10:0] last_count = '0;
    logic [3:0] last_pid = '0;

    always @(negedge clock) begin
        if (m_valid) got_q.push_back(m_data);
        if (m_done) begin
            done_n      <= done_n + 1;
            last_crc_ok <= m_crc_ok;
            last_count  <= m_count;
            last_pid    <= m_pid;
        end
        if (m_error) err_n <= err_n + 1;
    end

    int unsigned checks_n = 0, errors_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] pkt[$];
    logic tx_bits[$];
    int os_cur = 4, jit_mode = 0, cur_e = 0;

    function automatic void add_crc16();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 1; i < pkt.size(); i++)
            for (int k = 0; k < 8; k++)
                c = (pkt[i][k] ^ c[0]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        c = ~c;
        pkt.push_back(c[7:0]);
        pkt.push_back(c[15:8]);
    endfunction

    // SYNC, then bytes LSB-first with a 0 stuffed after six 1s; bad_at>=0 inserts seven raw 1s there.
    function automatic void build_stream(input int bad_at);
        int ones;
        logic v;
        tx_bits.delete();
        for (int i = 0; i < 7; i++) tx_bits.push_back(1'b0);
        tx_bits.push_back(1'b1);
        ones = 1;
        for (int i = 0; i < pkt.size(); i++) begin
            if (i == bad_at) begin
                for (int k = 0; k < 7; k++) tx_bits.push_back(1'b1);
                return;
            end
            for (int k = 0; k < 8; k++) begin
                v = pkt[i][k];
                tx_bits.push_back(v);
                if (v) begin
                    ones++;
                    if (ones == 6) begin
                        tx_bits.push_back(1'b0);
                        ones = 0;
                    end
                end else begin
                    ones = 0;
                end
            end
        end
    endfunction

    task automatic drive_sym(input logic [1:0] ls);
        int ne, dur;
        case (jit_mode)
            1:       ne = int'($urandom_range(1, 0));
            2:       ne = int'($urandom_range(1, 0)) - 1;
            3:       ne = int'($urandom_range(2, 0)) - 1;
            default: ne = 0;
        endcase
        dur   = os_cur + ne - cur_e;
        cur_e = ne;
        {dp_drv, dn_drv} = ls;
        repeat (dur) @(negedge clock);
    endtask

    task automatic send_stream(input int n, input bit with_eop);
        logic [1:0] lvl;
        lvl   = 2'b10;
        cur_e = 0;
        @(negedge clock);
        for (int i = 0; i < n; i++) begin
            if (!tx_bits[i]) lvl = ~lvl;
            drive_sym(lvl);
        end
        if (with_eop) begin
            drive_sym(2'b00);
            drive_sym(2'b00);
            for (int i = 0; i < 9; i++) drive_sym(2'b10);
        end
    endtask

    task automatic run_pkt(input string name, input int bad_at, input int exp_bytes,
                           input int exp_done, input int exp_err, input logic exp_crc);
        int g0, d0, e0;
        g0 = got_q.size();
        d0 = int'(done_n);
        e0 = int'(err_n);
        build_stream(bad_at);
        send_stream(tx_bits.size(), 1'b1);
        check($sformatf("%s_nbytes", name), got_q.size() - g0, exp_bytes);
        for (int i = 0; i < exp_bytes && g0 + i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), got_q[g0 + i], pkt[i]);
        check($sformatf("%s_done", name), int'(done_n) - d0, exp_done);
        check($sformatf("%s_error", name), int'(err_n) - e0, exp_err);
        if (exp_done != 0) begin
            check($sformatf("%s_count", name), last_count, pkt.size());
            check($sformatf("%s_crc_ok", name), last_crc_ok, exp_crc);
            check($sformatf("%s_pid", name), last_pid, pkt[0] & 8'h0F);
        end
    endtask

    function automatic void data0_setup_pkt();
        pkt = '{8'hC3, 8'h80, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        add_crc16();
    endfunction

    initial begin
        int d0, e0;
        sel = 1'b0;
        dp_drv = 1'b1;
        dn_drv = 1'b0;
        reset_n = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        check("reset_outputs", {m_active, m_valid, m_done, m_crc_ok, m_error, m_data, m_pid, m_count}, '0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check("idle_active", m_active, 1'b0);

        pkt = '{8'hD2};
        run_pkt("ack", -1, 1, 1, 0, 1'b1);
        pkt = '{8'h2D, 8'h00, 8'h10};
        run_pkt("setup", -1, 3, 1, 0, 1'b1);
        pkt = '{8'h2D, 8'h01, 8'h10};
        run_pkt("setup_badcrc", -1, 3, 1, 0, 1'b0);
        data0_setup_pkt();
        run_pkt("data0", -1, 11, 1, 0, 1'b1);
        pkt = '{8'hC3, 8'hFF, 8'hFF};
        add_crc16();
        run_pkt("data0_ffff", -1, 5, 1, 0, 1'b1);
        pkt = '{8'hD3};
        run_pkt("bad_pid", -1, 0, 0, 1, 1'b0);
        data0_setup_pkt();
        run_pkt("seven_ones", 3, 3, 0, 1, 1'b0);
        pkt = '{8'hD2};
        run_pkt("ack_after_err", -1, 1, 1, 0, 1'b1);

        data0_setup_pkt();
        jit_mode = 1;
        run_pkt("jit_late", -1, 11, 1, 0, 1'b1);
        jit_mode = 2;
        run_pkt("jit_early", -1, 11, 1, 0, 1'b1);
        sel = 1'b1;
        os_cur = 8;
        jit_mode = 3;
        run_pkt("os8_jit", -1, 11, 1, 0, 1'b1);
        sel = 1'b0;
        os_cur = 4;
        jit_mode = 0;
        repeat (20) @(negedge clock);

        // Mid-packet reset: stop driving partway through DATA0, then pulse reset.
        data0_setup_pkt();
        build_stream(-1);
        d0 = int'(done_n);
        e0 = int'(err_n);
        send_stream(40, 1'b0);
        check("mid_active", m_active, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {m_active, m_valid, m_done, m_crc_ok, m_error, m_data, m_pid, m_count}, '0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        {dp_drv, dn_drv} = 2'b10;
        repeat (60) @(negedge clock);
        check("midreset_no_done", int'(done_n) - d0, 0);
        check("midreset_no_error", int'(err_n) - e0, 0);
        pkt = '{8'hD2};
        run_pkt("ack_after_reset", -1, 1, 1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
